// File: rtl/hub75_bcm_sched.sv
// HUB75 bit-plane scheduler: walks the enabled bit-planes of one row LSB to MSB.
// Optional macro HUB75_BCM_SCHED_ADDR_AT_LATCH_EN moves the PHY row update to LATCH.
//
// state | meaning
// IDLE  | waiting for ctrl_go, ctrl_rdy high
// SHIFT | one-cycle shift request for the current plane
// WAIT  | wait for shifter and blanking to be idle
// PRE   | pre-latch delay, pre_len+1 cycles
// LATCH | phy_le high, latch_len+1 cycles
// POST  | post-latch delay, post_len+1 cycles
// BLANK | one-cycle blanking request, advance to next enabled plane
// DONE  | one-cycle completion strobe
module hub75_bcm_sched #(
  parameter int N_ROWS     = 32,
  parameter int N_PLANES   = 10,
  parameter int TIMER_W    = 8,
  parameter int LOG_N_ROWS = $clog2(N_ROWS)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [LOG_N_ROWS-1:0] phy_addr,
  output logic                  phy_le,
  output logic [N_PLANES-1:0]   shift_plane,
  output logic                  shift_go,
  input  logic                  shift_rdy,
  output logic [N_PLANES-1:0]   blank_plane,
  output logic                  blank_go,
  input  logic                  blank_rdy,
  input  logic [LOG_N_ROWS-1:0] ctrl_row,
  input  logic                  ctrl_go,
  output logic                  ctrl_rdy,
  output logic                  ctrl_done,
  input  logic [N_PLANES-1:0]   cfg_plane_mask,
  input  logic [TIMER_W-1:0]    cfg_pre_latch_len,
  input  logic [TIMER_W-1:0]    cfg_latch_len,
  input  logic [TIMER_W-1:0]    cfg_post_latch_len
);

  typedef enum logic [2:0] {
    IDLE, SHIFT, WAIT, PRE, LATCH, POST, BLANK, DONE
  } state_t;

  localparam logic [N_PLANES-1:0] P_ONE = N_PLANES'(1);
  localparam logic [TIMER_W:0]    T_ONE = (TIMER_W+1)'(1);

  state_t                state, state_d;
  logic [N_PLANES-1:0]   mask_q, mask_d;
  logic [N_PLANES-1:0]   plane, plane_d;
  logic [TIMER_W:0]      timer, timer_d;
  logic [N_PLANES-1:0]   lowest, above, next_plane;
  logic                  accept;

  assign accept = (state == IDLE) && ctrl_go;

  // Isolate-lowest-set-bit tricks give one-hot planes without a priority loop.
  always_comb begin
    lowest     = cfg_plane_mask & (~cfg_plane_mask + P_ONE);
    above      = mask_q & ~(plane | (plane - P_ONE));
    next_plane = above & (~above + P_ONE);
  end

  always_comb begin
    state_d = state;
    mask_d  = mask_q;
    plane_d = plane;
    timer_d = timer;
    case (state)
      IDLE: begin
        if (ctrl_go) begin
          mask_d  = cfg_plane_mask;
          plane_d = lowest;
          state_d = (cfg_plane_mask == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: state_d = WAIT;
      WAIT: begin
        if (shift_rdy && blank_rdy) begin
          state_d = PRE;
          timer_d = {1'b0, cfg_pre_latch_len};
        end
      end
      PRE: begin
        if (timer == '0) begin
          state_d = LATCH;
          timer_d = {1'b0, cfg_latch_len};
        end else begin
          timer_d = timer - T_ONE;
        end
      end
      LATCH: begin
        if (timer == '0) begin
          state_d = POST;
          timer_d = {1'b0, cfg_post_latch_len};
        end else begin
          timer_d = timer - T_ONE;
        end
      end
      POST: begin
        if (timer == '0) begin
          state_d = BLANK;
        end else begin
          timer_d = timer - T_ONE;
        end
      end
      BLANK: begin
        if (above == '0) begin
          state_d = DONE;
        end else begin
          plane_d = next_plane;
          state_d = SHIFT;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      mask_q <= '0;
      plane  <= '0;
      timer  <= '0;
    end else begin
      state  <= state_d;
      mask_q <= mask_d;
      plane  <= plane_d;
      timer  <= timer_d;
    end
  end

`ifdef HUB75_BCM_SCHED_ADDR_AT_LATCH_EN
  logic [LOG_N_ROWS-1:0] addr;

  // Loading on entry to LATCH makes the row change coincide with the first latch cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr     <= '0;
      phy_addr <= '0;
    end else begin
      if (accept) addr <= ctrl_row;
      if (state_d == LATCH) phy_addr <= addr;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      phy_addr <= '0;
    end else if (accept) begin
      phy_addr <= ctrl_row;
    end
  end
`endif

  assign ctrl_rdy    = (state == IDLE);
  assign shift_go    = (state == SHIFT);
  assign blank_go    = (state == BLANK);
  assign phy_le      = (state == LATCH);
  assign ctrl_done   = (state == DONE);
  assign shift_plane = plane;
  assign blank_plane = plane;

endmodule

// File: tb/tb_hub75_bcm_sched.sv
// Self-checking bench for hub75_bcm_sched: directed and random rows against an arithmetic model.
module tb_hub75_bcm_sched;
  localparam int NR = 32;
  localparam int NP = 10;
  localparam int TW = 8;
  localparam int LR = $clog2(NR);

  logic          clk = 1'b0;
  logic          rst;
  logic [LR-1:0] phy_addr;
  logic          phy_le;
  logic [NP-1:0] shift_plane;
  logic          shift_go;
  logic          shift_rdy;
  logic [NP-1:0] blank_plane;
  logic          blank_go;
  logic          blank_rdy;
  logic [LR-1:0] ctrl_row;
  logic          ctrl_go;
  logic          ctrl_rdy;
  logic          ctrl_done;
  logic [NP-1:0] cfg_plane_mask;
  logic [TW-1:0] cfg_pre_latch_len;
  logic [TW-1:0] cfg_latch_len;
  logic [TW-1:0] cfg_post_latch_len;

  int n_cmp  = 0;
  int n_fail = 0;
  int last_row = 0;

  hub75_bcm_sched #(.N_ROWS(NR), .N_PLANES(NP), .TIMER_W(TW)) dut (
    .clk(clk), .rst(rst),
    .phy_addr(phy_addr), .phy_le(phy_le),
    .shift_plane(shift_plane), .shift_go(shift_go), .shift_rdy(shift_rdy),
    .blank_plane(blank_plane), .blank_go(blank_go), .blank_rdy(blank_rdy),
    .ctrl_row(ctrl_row), .ctrl_go(ctrl_go), .ctrl_rdy(ctrl_rdy), .ctrl_done(ctrl_done),
    .cfg_plane_mask(cfg_plane_mask), .cfg_pre_latch_len(cfg_pre_latch_len),
    .cfg_latch_len(cfg_latch_len), .cfg_post_latch_len(cfg_post_latch_len)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One row: go at cycle 0, then sample every cycle on the falling edge until ctrl_done.
  task automatic run_row(input int row, input logic [NP-1:0] mask,
                         input int pre, input int lat, input int post, input int stall);
    int got_q[$];
    int exp_q[$];
    int cyc, done_cyc, done_cnt, le_cnt, blank_cnt, run_len, bad_run;
    int addr_err, plane_mis, stall_start, n, cost, extra, exp_addr;
    bit le_seen, stalled;
    done_cyc = -1; done_cnt = 0; le_cnt = 0; blank_cnt = 0; run_len = 0; bad_run = 0;
    addr_err = 0; plane_mis = 0; stall_start = -1; le_seen = 0; stalled = 0;

    for (int i = 0; i < NP; i++) if (mask[i]) exp_q.push_back(1 << i);
    n     = exp_q.size();
    cost  = pre + lat + post + 6;
    extra = (stall > 2 && n > 1) ? stall - 2 : 0;

    @(negedge clk);
    check("rdy_before_go", ctrl_rdy, 1);
    ctrl_row           = LR'(row);
    cfg_plane_mask     = mask;
    cfg_pre_latch_len  = TW'(pre);
    cfg_latch_len      = TW'(lat);
    cfg_post_latch_len = TW'(post);
    ctrl_go            = 1'b1;
    @(negedge clk);
    ctrl_go = 1'b0;
    cyc = 1;
    while (cyc < 4000 && done_cyc < 0) begin
      if (shift_go) got_q.push_back(int'(shift_plane));
      if (blank_plane !== shift_plane) plane_mis++;
      if (phy_le) begin
        le_cnt++; run_len++; le_seen = 1;
      end else if (run_len != 0) begin
        if (run_len != lat + 1) bad_run++;
        run_len = 0;
      end
`ifdef HUB75_BCM_SCHED_ADDR_AT_LATCH_EN
      exp_addr = le_seen ? row : last_row;
`else
      exp_addr = row;
`endif
      if (int'(phy_addr) != exp_addr) addr_err++;
      if (ctrl_go) ctrl_go = 1'b0;
      if (blank_go) begin
        blank_cnt++;
        if (stall > 0 && !stalled) begin
          stalled = 1; stall_start = cyc; blank_rdy = 1'b0;
        end
      end
      if (stalled && cyc == stall_start + 3) begin
        cfg_plane_mask = ~mask;
        ctrl_go        = 1'b1;
      end
      if (stalled && cyc == stall_start + stall) blank_rdy = 1'b1;
      if (ctrl_done) begin
        done_cnt++; done_cyc = cyc;
        check("rdy_low_at_done", ctrl_rdy, 0);
      end
      @(negedge clk);
      cyc++;
    end
    blank_rdy = 1'b1;
    check("rdy_after_done", ctrl_rdy, 1);
    check("done_single", ctrl_done, 0);
    check("plane_count", got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++)
      check("plane_order", got_q[i], exp_q[i]);
    check("le_cycles", le_cnt, n * (lat + 1));
    check("le_run_len", bad_run, 0);
    check("blank_count", blank_cnt, n);
    check("done_count", done_cnt, 1);
    check("done_cycle", done_cyc, (n == 0) ? 1 : n * cost + 1 + extra);
    check("addr_track", addr_err, 0);
    check("blank_eq_shift", plane_mis, 0);
    last_row = row;
  endtask

  task automatic reset_mid_latch(input int row);
    int cyc, seen, done_cnt, shift_cnt;
    seen = 0;
    @(negedge clk);
    ctrl_row = LR'(row); cfg_plane_mask = '1;
    cfg_pre_latch_len = 2; cfg_latch_len = 3; cfg_post_latch_len = 1;
    ctrl_go = 1'b1;
    @(negedge clk);
    ctrl_go = 1'b0;
    for (cyc = 0; cyc < 200 && !seen; cyc++) begin
      if (phy_le) seen = 1;
      else @(negedge clk);
    end
    check("latch_reached", seen, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_le", phy_le, 0);
    check("rst_rdy", ctrl_rdy, 1);
    check("rst_shift_go", shift_go, 0);
    check("rst_blank_go", blank_go, 0);
    check("rst_done", ctrl_done, 0);
    check("rst_addr", phy_addr, 0);
    done_cnt = 0; shift_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ctrl_done) done_cnt++;
      if (shift_go) shift_cnt++;
    end
    check("rst_no_done", done_cnt, 0);
    check("rst_no_shift", shift_cnt, 0);
    last_row = 0;
  endtask

  initial begin
    rst = 1'b1; ctrl_go = 1'b0; ctrl_row = '0; cfg_plane_mask = '0;
    cfg_pre_latch_len = '0; cfg_latch_len = '0; cfg_post_latch_len = '0;
    shift_rdy = 1'b1; blank_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_rdy", ctrl_rdy, 1);
    check("reset_le", phy_le, 0);
    check("reset_shift_go", shift_go, 0);
    check("reset_blank_go", blank_go, 0);
    check("reset_done", ctrl_done, 0);
    check("reset_addr", phy_addr, 0);
    check("reset_plane", shift_plane, 0);
    rst = 1'b0;

    run_row(3, 10'h3FF, 2, 3, 1, 0);
    run_row(5, 10'h0A4, 2, 3, 1, 0);
    run_row(7, 10'h000, 2, 3, 1, 0);
    run_row(9, 10'h3FF, 1, 1, 1, 7);
    for (int k = 0; k < 6; k++)
      run_row($urandom_range(0, NR - 1), NP'($urandom_range(0, 1023)),
              $urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), 0);
    reset_mid_latch(12);
    run_row(5, 10'h021, 1, 2, 0, 0);
    run_row(9, 10'h300, 0, 1, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
